// File: rtl/mem_port_arbiter_pkg.sv
// lc3b_types: shared LC-3b word/mask types plus the enums used by mem_port_arbiter.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_A,
        BUSY_B,
        RESP_A,
        RESP_B
    } arb_state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } arb_port_t;

    localparam lc3b_mem_wmask WMASK_FULL = 2'b11;

endpackage

// File: rtl/arb_req_capture.sv
// arb_req_capture: holds the granted request (address/op/wdata/wmask) and the
// returned read data so the lower memory never sees requester-side changes.
module arb_req_capture
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_req_i,
    input  logic [15:0] addr_i,
    input  logic        write_i,
    input  logic [15:0] wdata_i,
    input  logic [1:0]  wmask_i,
    input  logic        load_rdata_i,
    input  logic [15:0] rdata_i,
    output logic [15:0] addr_o,
    output logic        write_o,
    output logic [15:0] wdata_o,
    output logic [1:0]  wmask_o,
    output logic [15:0] rdata_o
);

    lc3b_word      addr_q;
    logic          write_q;
    lc3b_word      wdata_q;
    lc3b_mem_wmask wmask_q;
    lc3b_word      rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (load_req_i) begin
            addr_q  <= addr_i;
            write_q <= write_i;
            wdata_q <= wdata_i;
            wmask_q <= wmask_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (load_rdata_i) begin
            rdata_q <= rdata_i;
        end
    end

    assign addr_o  = addr_q;
    assign write_o = write_q;
    assign wdata_o = wdata_q;
    assign wmask_o = wmask_q;
    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises the LC-3b fetch port (A) and data port (B) onto one pmem interface.
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention instead of strict B priority.
module mem_port_arbiter
    import lc3b_types::*;
#(
    parameter int PMEM_TIMEOUT = 0
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_addr1,
    input  logic        mem_read1,
    output logic [15:0] mem_rdata1,
    output logic        resp_a,
    input  logic [15:0] mem_addr2,
    input  logic        mem_read2,
    input  logic        mem_write2,
    input  logic [15:0] mem_wdata2,
    input  logic [1:0]  mem_byte_enable2,
    output logic [15:0] mem_rdata2,
    output logic        resp_b,
    output logic [15:0] pmem_address,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_wdata,
    output logic [1:0]  pmem_byte_enable,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp,
    output logic        pmem_error
);

    localparam int TW = (PMEM_TIMEOUT > 0) ? $clog2(PMEM_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = (PMEM_TIMEOUT > 0) ? TW'(PMEM_TIMEOUT - 1) : '0;

    arb_state_t    state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          req_a, req_b, grant_b;
    logic          load_req, sel_b, load_rdata;
    lc3b_word      rdata_in;
    lc3b_word      cap_addr_in, cap_wdata_in;
    lc3b_mem_wmask cap_wmask_in;
    logic          cap_write_in;

    lc3b_word      cap_addr_q, cap_wdata_q, cap_rdata_q;
    lc3b_mem_wmask cap_wmask_q;
    logic          cap_write_q;
    logic          busy;

    assign req_a = mem_read1;
    assign req_b = mem_read2 | mem_write2;

`ifdef ARB_ROUND_ROBIN_EN
    arb_port_t last_q, last_d;

    assign grant_b = req_b && (!req_a || (last_q == PORT_A));

    always_comb begin
        last_d = last_q;
        if (load_req) begin
            last_d = sel_b ? PORT_B : PORT_A;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= PORT_A;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign grant_b = req_b;
`endif

    // A write on port B wins over a simultaneous read; fetches always use a full-word mask.
    assign cap_addr_in  = sel_b ? mem_addr2 : mem_addr1;
    assign cap_write_in = sel_b & mem_write2;
    assign cap_wdata_in = sel_b ? mem_wdata2 : '0;
    assign cap_wmask_in = sel_b ? mem_byte_enable2 : WMASK_FULL;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        load_req   = 1'b0;
        sel_b      = 1'b0;
        load_rdata = 1'b0;
        rdata_in   = pmem_rdata;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (grant_b) begin
                    load_req = 1'b1;
                    sel_b    = 1'b1;
                    state_d  = BUSY_B;
                end else if (req_a) begin
                    load_req = 1'b1;
                    state_d  = BUSY_A;
                end
            end
            BUSY_A, BUSY_B: begin
                if (pmem_resp) begin
                    load_rdata = 1'b1;
                    state_d    = (state_q == BUSY_A) ? RESP_A : RESP_B;
                end else if ((PMEM_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    load_rdata = 1'b1;
                    rdata_in   = '0;
                    err_d      = 1'b1;
                    state_d    = (state_q == BUSY_A) ? RESP_A : RESP_B;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP_A, RESP_B: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    arb_req_capture u_capture (
        .clk          (clk),
        .reset        (reset),
        .load_req_i   (load_req),
        .addr_i       (cap_addr_in),
        .write_i      (cap_write_in),
        .wdata_i      (cap_wdata_in),
        .wmask_i      (cap_wmask_in),
        .load_rdata_i (load_rdata),
        .rdata_i      (rdata_in),
        .addr_o       (cap_addr_q),
        .write_o      (cap_write_q),
        .wdata_o      (cap_wdata_q),
        .wmask_o      (cap_wmask_q),
        .rdata_o      (cap_rdata_q)
    );

    // Strobes decode straight from state so an async reset drops them in the same cycle.
    assign busy             = (state_q == BUSY_A) || (state_q == BUSY_B);
    assign pmem_read        = busy & ~cap_write_q;
    assign pmem_write       = busy & cap_write_q;
    assign pmem_address     = cap_addr_q;
    assign pmem_wdata       = cap_wdata_q;
    assign pmem_byte_enable = cap_wmask_q;
    assign pmem_error       = err_q;

    assign resp_a     = (state_q == RESP_A);
    assign resp_b     = (state_q == RESP_B);
    assign mem_rdata1 = cap_rdata_q;
    assign mem_rdata2 = cap_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random scenarios against a word-level memory model
// and an arbitration-order model; the DUT is built with PMEM_TIMEOUT = 8.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mem_addr1 = '0;
    logic        mem_read1 = 1'b0;
    logic [15:0] mem_rdata1;
    logic        resp_a;
    logic [15:0] mem_addr2 = '0;
    logic        mem_read2 = 1'b0;
    logic        mem_write2 = 1'b0;
    logic [15:0] mem_wdata2 = '0;
    logic [1:0]  mem_byte_enable2 = '0;
    logic [15:0] mem_rdata2;
    logic        resp_b;
    logic [15:0] pmem_address;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_rdata = '0;
    logic        pmem_resp = 1'b0;
    logic        pmem_error;

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_mem    [0:65535];
    logic [15:0] pmem_store [0:65535];
    int          pmem_delay = 0;
    bit          responder_on = 1'b1;
    int          wait_cnt = 0;
    bit          last_b = 1'b0;

    mem_port_arbiter #(.PMEM_TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_addr1        (mem_addr1),
        .mem_read1        (mem_read1),
        .mem_rdata1       (mem_rdata1),
        .resp_a           (resp_a),
        .mem_addr2        (mem_addr2),
        .mem_read2        (mem_read2),
        .mem_write2       (mem_write2),
        .mem_wdata2       (mem_wdata2),
        .mem_byte_enable2 (mem_byte_enable2),
        .mem_rdata2       (mem_rdata2),
        .resp_b           (resp_b),
        .pmem_address     (pmem_address),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_wdata       (pmem_wdata),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp),
        .pmem_error       (pmem_error)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] merge(logic [15:0] old, logic [15:0] wd, logic [1:0] m);
        return {m[1] ? wd[15:8] : old[15:8], m[0] ? wd[7:0] : old[7:0]};
    endfunction

    // Which port the arbiter should grant when ra/rb are presented in IDLE.
    function automatic bit model_pick_b(bit ra, bit rb);
        if (!rb) return 1'b0;
        if (!ra) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        return !last_b;
`else
        return 1'b1;
`endif
    endfunction

    // Lower memory: answers pmem_delay strobe cycles after the strobe first appears.
    initial begin
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (reset || !(pmem_read || pmem_write)) begin
                wait_cnt = 0;
            end else if (responder_on) begin
                if (wait_cnt == pmem_delay) begin
                    pmem_resp = 1'b1;
                    if (pmem_write) begin
                        pmem_store[pmem_address] = merge(pmem_store[pmem_address], pmem_wdata, pmem_byte_enable);
                        pmem_rdata = 16'($urandom);
                    end else begin
                        pmem_rdata = pmem_store[pmem_address];
                    end
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic wait_resp(output int n, output bit got_a, output bit got_b);
        n = 0;
        got_a = 1'b0;
        got_b = 1'b0;
        while (n < 40 && !got_a && !got_b) begin
            @(negedge clk);
            n++;
            got_a = resp_a;
            got_b = resp_b;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({resp_a, resp_b, pmem_read, pmem_write, pmem_error} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {resp_a, resp_b, pmem_read, pmem_write, pmem_error});
        end
        checks++;
        if ({pmem_address, pmem_wdata, pmem_byte_enable} !== 34'h0) begin
            errors++;
            $display("[TB] FAIL reset_pmem_bus: got %h expected 0", {pmem_address, pmem_wdata, pmem_byte_enable});
        end
        checks++;
        if ({mem_rdata1, mem_rdata2} !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_rdata: got %h expected 0", {mem_rdata1, mem_rdata2});
        end
        reset = 1'b0;
        last_b = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({resp_a, resp_b, pmem_read, pmem_write} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL idle_no_request: got %b expected 0000", {resp_a, resp_b, pmem_read, pmem_write});
        end
    endtask

    task automatic test_port_a_read;
        int n;
        bit ga, gb;
        pmem_store[16'h0040] = 16'h1234;
        ref_mem[16'h0040]    = 16'h1234;
        pmem_delay = 2;
        @(negedge clk);
        mem_addr1 = 16'h0040;
        mem_read1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({pmem_read, pmem_write, pmem_address, pmem_byte_enable} !== {2'b10, 16'h0040, 2'b11}) begin
            errors++;
            $display("[TB] FAIL a_read_strobe: got %h expected %h", {pmem_read, pmem_write, pmem_address, pmem_byte_enable}, {2'b10, 16'h0040, 2'b11});
        end
        wait_resp(n, ga, gb);
        checks++;
        if ({ga, gb} !== 2'b10 || n != pmem_delay + 1) begin
            errors++;
            $display("[TB] FAIL a_read_resp: got resp=%b after %0d expected 10 after %0d", {ga, gb}, n, pmem_delay + 1);
        end
        checks++;
        if (mem_rdata1 !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL a_read_data: got %h expected 1234", mem_rdata1);
        end
        last_b = 1'b0;
        mem_read1 = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL a_resp_pulse: got %b expected 0", resp_a);
        end
    endtask

    task automatic test_port_b_write;
        int n;
        bit ga, gb;
        logic [15:0] expv;
        pmem_delay = 1;
        @(negedge clk);
        mem_addr2 = 16'h8002;
        mem_wdata2 = 16'hBEEF;
        mem_byte_enable2 = 2'b10;
        mem_write2 = 1'b1;
        @(negedge clk);
        checks++;
        if ({pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable} !== {2'b01, 16'h8002, 16'hBEEF, 2'b10}) begin
            errors++;
            $display("[TB] FAIL b_write_strobe: got %h expected %h", {pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable}, {2'b01, 16'h8002, 16'hBEEF, 2'b10});
        end
        wait_resp(n, ga, gb);
        checks++;
        if ({ga, gb} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL b_write_resp: got %b expected 01", {ga, gb});
        end
        ref_mem[16'h8002] = merge(ref_mem[16'h8002], 16'hBEEF, 2'b10);
        expv = ref_mem[16'h8002];
        last_b = 1'b1;
        mem_write2 = 1'b0;
        @(negedge clk);
        mem_read2 = 1'b1;
        @(negedge clk);
        wait_resp(n, ga, gb);
        checks++;
        if ({ga, gb} !== 2'b01 || mem_rdata2 !== expv) begin
            errors++;
            $display("[TB] FAIL b_readback: got resp=%b data=%h expected 01 data=%h", {ga, gb}, mem_rdata2, expv);
        end
        last_b = 1'b1;
        mem_read2 = 1'b0;
    endtask

    task automatic test_simultaneous;
        int n;
        bit ga, gb, first_b;
        pmem_store[16'h0010] = 16'hA0A0;
        ref_mem[16'h0010]    = 16'hA0A0;
        pmem_store[16'h2000] = 16'hB0B0;
        ref_mem[16'h2000]    = 16'hB0B0;
        first_b = model_pick_b(1'b1, 1'b1);
        pmem_delay = 1;
        @(negedge clk);
        mem_addr1 = 16'h0010;
        mem_read1 = 1'b1;
        mem_addr2 = 16'h2000;
        mem_read2 = 1'b1;
        @(negedge clk);
        checks++;
        if (pmem_address !== (first_b ? 16'h2000 : 16'h0010)) begin
            errors++;
            $display("[TB] FAIL both_first_addr: got %h expected %h", pmem_address, first_b ? 16'h2000 : 16'h0010);
        end
        wait_resp(n, ga, gb);
        checks++;
        if ({ga, gb} !== {!first_b, first_b} || (first_b ? mem_rdata2 : mem_rdata1) !== (first_b ? 16'hB0B0 : 16'hA0A0)) begin
            errors++;
            $display("[TB] FAIL both_first_resp: got resp=%b a=%h b=%h expected first_b=%b", {ga, gb}, mem_rdata1, mem_rdata2, first_b);
        end
        last_b = first_b;
        if (first_b) mem_read2 = 1'b0;
        else mem_read1 = 1'b0;
        wait_resp(n, ga, gb);
        checks++;
        if ({ga, gb} !== {first_b, !first_b} || n != pmem_delay + 3 || (first_b ? mem_rdata1 : mem_rdata2) !== (first_b ? 16'hA0A0 : 16'hB0B0)) begin
            errors++;
            $display("[TB] FAIL both_second_resp: got resp=%b after %0d a=%h b=%h expected after %0d", {ga, gb}, n, mem_rdata1, mem_rdata2, pmem_delay + 3);
        end
        last_b = !first_b;
        mem_read1 = 1'b0;
        mem_read2 = 1'b0;
    endtask

    task automatic test_addr_hold;
        bit seen;
        pmem_store[16'h3000] = 16'h3C3C;
        ref_mem[16'h3000]    = 16'h3C3C;
        pmem_store[16'h4000] = 16'h4C4C;
        ref_mem[16'h4000]    = 16'h4C4C;
        pmem_delay = 4;
        seen = 1'b0;
        @(negedge clk);
        mem_addr2 = 16'h3000;
        mem_read2 = 1'b1;
        @(negedge clk);
        mem_addr2 = 16'h4000;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            checks++;
            if (pmem_address !== 16'h3000) begin
                errors++;
                $display("[TB] FAIL addr_hold: got %h expected 3000", pmem_address);
            end
            seen = resp_b;
        end
        checks++;
        if (!seen || mem_rdata2 !== 16'h3C3C) begin
            errors++;
            $display("[TB] FAIL addr_hold_data: got seen=%b data=%h expected 1 3c3c", seen, mem_rdata2);
        end
        last_b = 1'b1;
        mem_read2 = 1'b0;
    endtask

    task automatic test_reset_mid;
        int n;
        bit ga, gb;
        responder_on = 1'b0;
        @(negedge clk);
        mem_addr2 = 16'h5000;
        mem_wdata2 = 16'h1111;
        mem_byte_enable2 = 2'b11;
        mem_write2 = 1'b1;
        @(negedge clk);
        checks++;
        if (pmem_write !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_busy: got pmem_write=%b expected 1", pmem_write);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({pmem_read, pmem_write, resp_a, resp_b} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_drop: got %b expected 0000", {pmem_read, pmem_write, resp_a, resp_b});
        end
        @(negedge clk);
        reset = 1'b0;
        last_b = 1'b0;
        mem_write2 = 1'b0;
        responder_on = 1'b1;
        pmem_delay = 0;
        @(negedge clk);
        mem_read2 = 1'b1;
        @(negedge clk);
        checks++;
        if ({pmem_read, pmem_write, pmem_address} !== {2'b10, 16'h5000}) begin
            errors++;
            $display("[TB] FAIL after_reset_strobe: got %h expected %h", {pmem_read, pmem_write, pmem_address}, {2'b10, 16'h5000});
        end
        wait_resp(n, ga, gb);
        checks++;
        if ({ga, gb} !== 2'b01 || mem_rdata2 !== ref_mem[16'h5000]) begin
            errors++;
            $display("[TB] FAIL after_reset_read: got resp=%b data=%h expected 01 data=%h", {ga, gb}, mem_rdata2, ref_mem[16'h5000]);
        end
        last_b = 1'b1;
        mem_read2 = 1'b0;
    endtask

    task automatic test_random;
        for (int it = 0; it < 40; it++) begin
            bit ra, rb, first_b, ga, gb;
            int op, n, d1, d2;
            logic [15:0] aa, ab, wd, exp_addr;
            logic [1:0] m, exp_rw;
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) rb = 1'b1;
            op = $urandom_range(0, 2);
            aa = 16'h1000 + 16'($urandom_range(0, 15));
            ab = 16'h1000 + 16'($urandom_range(0, 15));
            wd = 16'($urandom);
            m  = 2'($urandom);
            d1 = $urandom_range(0, 5);
            first_b = model_pick_b(ra, rb);
            @(negedge clk);
            mem_addr1 = aa;
            mem_read1 = ra;
            mem_addr2 = ab;
            mem_read2 = rb && (op != 1);
            mem_write2 = rb && (op != 0);
            mem_wdata2 = wd;
            mem_byte_enable2 = m;
            pmem_delay = d1;
            exp_addr = first_b ? ab : aa;
            exp_rw = (first_b && op != 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            checks++;
            if ({pmem_read, pmem_write, pmem_address} !== {exp_rw, exp_addr}) begin
                errors++;
                $display("[TB] FAIL rnd_strobe it=%0d: got %h expected %h", it, {pmem_read, pmem_write, pmem_address}, {exp_rw, exp_addr});
            end
            wait_resp(n, ga, gb);
            checks++;
            if ({ga, gb} !== {!first_b, first_b} || n != d1 + 1) begin
                errors++;
                $display("[TB] FAIL rnd_first_resp it=%0d: got resp=%b after %0d expected %b after %0d", it, {ga, gb}, n, {!first_b, first_b}, d1 + 1);
            end
            if (first_b && op != 0) begin
                ref_mem[ab] = merge(ref_mem[ab], wd, m);
            end else begin
                checks++;
                if ((first_b ? mem_rdata2 : mem_rdata1) !== ref_mem[exp_addr]) begin
                    errors++;
                    $display("[TB] FAIL rnd_first_data it=%0d: got %h expected %h", it, first_b ? mem_rdata2 : mem_rdata1, ref_mem[exp_addr]);
                end
            end
            last_b = first_b;
            if (first_b) begin
                mem_read2 = 1'b0;
                mem_write2 = 1'b0;
            end else begin
                mem_read1 = 1'b0;
            end
            if (ra && rb) begin
                d2 = $urandom_range(0, 5);
                pmem_delay = d2;
                wait_resp(n, ga, gb);
                checks++;
                if ({ga, gb} !== {first_b, !first_b} || n != d2 + 3) begin
                    errors++;
                    $display("[TB] FAIL rnd_second_resp it=%0d: got resp=%b after %0d expected %b after %0d", it, {ga, gb}, n, {first_b, !first_b}, d2 + 3);
                end
                if (!first_b && op != 0) begin
                    ref_mem[ab] = merge(ref_mem[ab], wd, m);
                end else begin
                    checks++;
                    if ((first_b ? mem_rdata1 : mem_rdata2) !== ref_mem[first_b ? aa : ab]) begin
                        errors++;
                        $display("[TB] FAIL rnd_second_data it=%0d: got %h expected %h", it, first_b ? mem_rdata1 : mem_rdata2, ref_mem[first_b ? aa : ab]);
                    end
                end
                last_b = !first_b;
                mem_read1 = 1'b0;
                mem_read2 = 1'b0;
                mem_write2 = 1'b0;
            end
        end
    endtask

    task automatic test_timeout;
        int n;
        bit ga, gb;
        pmem_store[16'h0100] = 16'h7777;
        ref_mem[16'h0100]    = 16'h7777;
        checks++;
        if (pmem_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL error_before_timeout: got %b expected 0", pmem_error);
        end
        responder_on = 1'b0;
        @(negedge clk);
        mem_addr1 = 16'h0100;
        mem_read1 = 1'b1;
        @(negedge clk);
        wait_resp(n, ga, gb);
        checks++;
        if ({ga, gb} !== 2'b10 || n != TIMEOUT || mem_rdata1 !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL timeout_resp: got resp=%b after %0d data=%h expected 10 after %0d data=0000", {ga, gb}, n, mem_rdata1, TIMEOUT);
        end
        checks++;
        if (pmem_error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_error_set: got %b expected 1", pmem_error);
        end
        last_b = 1'b0;
        mem_read1 = 1'b0;
        responder_on = 1'b1;
        pmem_delay = 0;
        @(negedge clk);
        mem_read1 = 1'b1;
        @(negedge clk);
        wait_resp(n, ga, gb);
        checks++;
        if ({ga, gb} !== 2'b10 || mem_rdata1 !== 16'h7777 || pmem_error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL error_sticky: got resp=%b data=%h err=%b expected 10 7777 1", {ga, gb}, mem_rdata1, pmem_error);
        end
        mem_read1 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ref_mem[i]    = 16'($urandom);
            pmem_store[i] = ref_mem[i];
        end
        test_reset();
        test_port_a_read();
        test_port_b_write();
        test_simultaneous();
        test_addr_hold();
        test_reset_mid();
        test_random();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
